// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: handshaked instruction memory between fetch and decode.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/ready/addr     fetch request (byte PC)
//   rsp_valid/ready/data     fetch response, data is 0 on fault
//   rsp_fault                bit0 misaligned, bit1 out of range
//   ld_en/addr/data, ld_err  program-load write port, ld_err = dropped load
module instr_mem_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_fault,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_err
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // one extra bit so DEPTH itself is representable in the compare
    localparam logic [IW:0] DEPTH_C = (IW + 1)'(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] req_idx;
    logic [IW-1:0] ld_idx;
    logic          req_oor;
    logic          req_mis;
    logic [1:0]    req_fault;
    logic          ld_oor;
    logic          accept;
    logic          unused_bits;

    assign req_idx   = req_addr[ADDR_WIDTH-1:2];
    assign ld_idx    = ld_addr[ADDR_WIDTH-1:2];
    assign req_oor   = {1'b0, req_idx} >= DEPTH_C;
    assign ld_oor    = {1'b0, ld_idx} >= DEPTH_C;
    assign req_mis   = |req_addr[1:0];
    assign req_fault = {req_oor, req_mis};
    assign unused_bits = ^ld_addr[1:0];

    assign req_ready = rst & ~ld_en &
                       ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == RESP);

    // memory content survives reset
    always_ff @(posedge clk) begin
        if (ld_en && !ld_oor) begin
            mem[ld_idx[MW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (WS == 4'd0) ? RESP : WAIT;
                    cnt_nx   = WS;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        state_nx = (WS == 4'd0) ? RESP : WAIT;
                        cnt_nx   = WS;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // faulting fetches never index the array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data  <= '0;
            rsp_fault <= 2'b00;
            ld_err    <= 1'b0;
        end else begin
            ld_err <= ld_en & ld_oor;
            if (accept) begin
                rsp_fault <= req_fault;
                if (|req_fault) begin
                    rsp_data <= '0;
                end else begin
                    rsp_data <= mem[req_idx[MW-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb_instr_mem_pipe: directed and random checks of instr_mem_pipe
// with zero and three wait states, against a word-array reference model.
module tb_instr_mem_pipe;

    localparam int D  = 16;
    localparam int AW = $clog2(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, ld_err0;
    logic [31:0] req_addr0, rsp_data0;
    logic [1:0]  rsp_fault0;
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, ld_err3;
    logic [31:0] req_addr3, rsp_data3;
    logic [1:0]  rsp_fault3;

    instr_mem_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(D), .WAIT_STATES(0)
    ) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_data(rsp_data0), .rsp_fault(rsp_fault0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err0)
    );

    instr_mem_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(D), .WAIT_STATES(3)
    ) u3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_fault(rsp_fault3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_err(ld_err3)
    );

    int vectors = 0;
    int errs    = 0;

    logic [31:0] mm [D];

    typedef struct packed {
        logic [1:0]  f;
        logic [31:0] d;
    } rsp_t;

    rsp_t q[$];

    function automatic rsp_t exp_rsp(input logic [31:0] a);
        rsp_t r;
        r.f[0] = (a % 4) != 0;
        r.f[1] = (a / 4) >= D;
        r.d    = 32'h0;
        if (r.f == 2'b00) r.d = mm[a[AW+1:2]];
        return r;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] dt);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = dt;
        #1;
        chk1("ld_blocks_ready", req_ready0, 1'b0);
        @(negedge clk);
        ld_en = 1'b0;
        if ((a / 4) < D) mm[a[AW+1:2]] = dt;
        chk1("ld_err0", ld_err0, (a / 4) >= D);
        chk1("ld_err3", ld_err3, (a / 4) >= D);
    endtask

    task automatic fetch0(input logic [31:0] a);
        rsp_t e;
        e = exp_rsp(a);
        req_valid0 = 1'b1;
        req_addr0  = a;
        rsp_ready0 = 1'b1;
        #1;
        chk1("f_ready", req_ready0, 1'b1);
        @(negedge clk);
        req_valid0 = 1'b0;
        chk1("f_valid", rsp_valid0, 1'b1);
        chk32("f_data", rsp_data0, e.d);
        chk32("f_fault", 32'(rsp_fault0), 32'(e.f));
        @(negedge clk);
        chk1("f_idle", rsp_valid0, 1'b0);
    endtask

    initial begin
        rsp_t e;
        logic exp_lderr;

        rst = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
        req_valid3 = 1'b0; req_addr3 = '0; rsp_ready3 = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_valid", rsp_valid0, 1'b0);
        chk32("rst_data", rsp_data0, 32'h0);
        chk32("rst_fault", 32'(rsp_fault0), 32'h0);
        chk1("rst_lderr", ld_err0, 1'b0);
        chk1("rst_ready_low", req_ready0, 1'b0);
        rst = 1'b1;
        #1;
        chk1("rel_ready0", req_ready0, 1'b1);
        chk1("rel_ready3", req_ready3, 1'b1);
        @(negedge clk);

        load(32'h0, 32'h0062E233);
        load(32'h4, 32'h00832383);
        for (int i = 2; i < D; i++) load(32'(i * 4), $urandom);

        fetch0(32'h0);

        // back-to-back stream
        req_valid0 = 1'b1;
        rsp_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr0 = 32'(i * 4);
            e = exp_rsp(req_addr0);
            #1;
            chk1("b2b_ready", req_ready0, 1'b1);
            @(negedge clk);
            chk1("b2b_valid", rsp_valid0, 1'b1);
            chk32("b2b_data", rsp_data0, e.d);
        end
        req_valid0 = 1'b0;
        @(negedge clk);
        chk1("b2b_end", rsp_valid0, 1'b0);

        // backpressure
        req_addr0  = 32'h4;
        req_valid0 = 1'b1;
        rsp_ready0 = 1'b0;
        #1;
        chk1("bp_ready0", req_ready0, 1'b1);
        @(negedge clk);
        chk1("bp_valid", rsp_valid0, 1'b1);
        chk32("bp_data", rsp_data0, mm[1]);
        req_addr0 = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_ready_low", req_ready0, 1'b0);
            @(negedge clk);
            chk1("bp_hold_v", rsp_valid0, 1'b1);
            chk32("bp_hold_d", rsp_data0, mm[1]);
        end
        rsp_ready0 = 1'b1;
        #1;
        chk1("bp_release_ready", req_ready0, 1'b1);
        @(negedge clk);
        req_valid0 = 1'b0;
        chk1("bp_next_v", rsp_valid0, 1'b1);
        chk32("bp_next_d", rsp_data0, mm[2]);
        @(negedge clk);
        chk1("bp_end", rsp_valid0, 1'b0);

        // faults
        fetch0(32'h2);
        fetch0(32'(4 * D));
        fetch0(32'(4 * D + 1));
        fetch0(32'(4 * D + 6));
        load(32'(4 * D), 32'hDEADBEEF);
        @(negedge clk);
        chk1("lderr_pulse_end", ld_err0, 1'b0);
        fetch0(32'h0);

        // three wait states, load to same word while in flight
        e = exp_rsp(32'h8);
        req_valid3 = 1'b1;
        req_addr3  = 32'h8;
        #1;
        chk1("w3_ready", req_ready3, 1'b1);
        @(negedge clk);
        req_valid3 = 1'b0;
        chk1("w3_n1", rsp_valid3, 1'b0);
        ld_en   = 1'b1;
        ld_addr = 32'h8;
        ld_data = ~e.d;
        #1;
        chk1("w3_ld_ready3", req_ready3, 1'b0);
        chk1("w3_ld_ready0", req_ready0, 1'b0);
        @(negedge clk);
        ld_en = 1'b0;
        mm[2] = ~e.d;
        chk1("w3_n2", rsp_valid3, 1'b0);
        @(negedge clk);
        chk1("w3_n3", rsp_valid3, 1'b0);
        @(negedge clk);
        chk1("w3_n4", rsp_valid3, 1'b1);
        chk32("w3_data", rsp_data3, e.d);
        chk32("w3_fault", 32'(rsp_fault3), 32'h0);
        @(negedge clk);
        chk1("w3_done", rsp_valid3, 1'b0);
        req_valid3 = 1'b1;
        @(negedge clk);
        req_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        chk1("w3_new_v", rsp_valid3, 1'b1);
        chk32("w3_new_d", rsp_data3, mm[2]);
        @(negedge clk);

        // async reset mid-transaction
        req_valid0 = 1'b1; req_addr0 = 32'h4; rsp_ready0 = 1'b0;
        req_valid3 = 1'b1; req_addr3 = 32'hC;
        @(negedge clk);
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        chk1("ar_pre_v0", rsp_valid0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("ar_v0", rsp_valid0, 1'b0);
        chk32("ar_d0", rsp_data0, 32'h0);
        chk32("ar_f0", 32'(rsp_fault0), 32'h0);
        chk1("ar_v3", rsp_valid3, 1'b0);
        chk32("ar_d3", rsp_data3, 32'h0);
        chk32("ar_f3", 32'(rsp_fault3), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rsp_ready0 = 1'b1;
        #1;
        chk1("ar_ready0", req_ready0, 1'b1);
        chk1("ar_ready3", req_ready3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("ar_discard3", rsp_valid3, 1'b0);
            chk1("ar_discard0", rsp_valid0, 1'b0);
        end
        for (int i = 0; i < D; i++) fetch0(32'(i * 4));

        // random traffic on the zero-wait instance
        q.delete();
        exp_lderr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            chk1("rs_valid", rsp_valid0, q.size() != 0);
            if (rsp_valid0 && q.size() != 0) begin
                chk32("rs_data", rsp_data0, q[0].d);
                chk32("rs_fault", 32'(rsp_fault0), 32'(q[0].f));
            end
            chk1("rs_lderr", ld_err0, exp_lderr);
            ld_en      = ($urandom_range(0, 7) == 0);
            ld_addr    = $urandom_range(0, 4 * D + 7);
            ld_data    = $urandom;
            req_valid0 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0)
                req_addr0 = 4 * $urandom_range(0, D - 1);
            else
                req_addr0 = $urandom_range(0, 4 * D + 7);
            rsp_ready0 = ($urandom_range(0, 2) != 0);
            #1;
            chk1("rs_ready", req_ready0,
                 !ld_en && (q.size() == 0 || rsp_ready0));
            if (rsp_valid0 && rsp_ready0 && q.size() != 0)
                void'(q.pop_front());
            if (req_valid0 && req_ready0)
                q.push_back(exp_rsp(req_addr0));
            exp_lderr = ld_en && ((ld_addr / 4) >= D);
            if (ld_en && (ld_addr / 4) < D) mm[ld_addr[AW+1:2]] = ld_data;
            @(negedge clk);
        end
        ld_en = 1'b0;
        req_valid0 = 1'b0;
        rsp_ready0 = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
